decoder_nx_seq: RTL and testbench

Parametrised, registered successor to the 1-to-2 decoder. Converts a SEL_W-bit binary select into a one-hot N_OUT-bit output, clocked through an output register. Accepts a new select via a valid/ready handshake. Two output modes: LEVEL holds the one-hot output until the next select; PULSE drives it for a programmable number of cycles, then clears it. Used as the channel-strobe generator for downstream enables and chip-selects.

---
 rtl/decoder_nx_seq_pkg.sv | 23 ++
 rtl/decoder_nx_seq_pulse_timer.sv | 27 ++
 rtl/decoder_nx_seq.sv | 84 ++++++++
 tb/tb_decoder_nx_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/decoder_nx_seq_pkg.sv
// Shared types and helpers for the registered one-hot channel-strobe decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  localparam int MAX_OUT = 64;

  // Widest possible decode; callers truncate to their own output count.
  function automatic logic [MAX_OUT-1:0] onehot_dec(input logic [5:0] sel, input int n_out);
    logic [MAX_OUT-1:0] res;
    res = '0;
    if (int'(sel) < n_out) res[sel] = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/decoder_nx_seq_pulse_timer.sv
// Loadable down-counter that stops at zero; done flags an expired count.
module pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] count;

  assign done = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (!done) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered binary-to-one-hot decoder with LEVEL and timed PULSE output modes.
// Handshake: a select transfers on any cycle where sel_valid and sel_ready are both high.
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int N_OUT = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sel_valid,
  input  logic [SEL_W-1:0] sel,
  input  logic             mode,
  input  logic [CNT_W-1:0] pulse_len,
  output logic             sel_ready,
  output logic [N_OUT-1:0] y,
  output logic             busy,
  output logic             err,
  output logic [1:0]       state
);

  state_t             cur;
  logic               accept;
  logic               in_range;
  logic               load;
  logic               done;
  logic [MAX_OUT-1:0] dec;

  assign state     = cur;
  assign sel_ready = en && (cur != PULSE);
  assign accept    = sel_valid && sel_ready;
  assign in_range  = 32'(sel) < N_OUT;
  assign dec       = onehot_dec(6'(sel), N_OUT);
  assign load      = accept && in_range && (mode == MODE_PULSE);

  pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!en),
    .load  (load),
    .value (pulse_len),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= IDLE;
      y    <= '0;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      err <= 1'b0;
      if (!en) begin
        cur  <= IDLE;
        y    <= '0;
        busy <= 1'b0;
      end else if (accept) begin
        // Out-of-range selects are consumed but produce no strobe.
        if (!in_range) begin
          cur  <= IDLE;
          y    <= '0;
          busy <= 1'b0;
          err  <= 1'b1;
        end else begin
          y <= N_OUT'(dec);
          if (mode == MODE_PULSE) begin
            cur  <= PULSE;
            busy <= 1'b1;
          end else begin
            cur  <= HOLD;
            busy <= 1'b0;
          end
        end
      end else if (cur == PULSE && done) begin
        cur  <= IDLE;
        y    <= '0;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Drives an 8-output and a 6-output decoder with shared stimulus and scores both against a cycle model.
module tb_decoder_nx_seq;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       sel_valid = 1'b0;
  logic [2:0] sel = '0;
  logic       mode = 1'b0;
  logic [3:0] pulse_len = '0;

  logic       rdy8, busy8, err8, rdy6, busy6, err6;
  logic [7:0] y8;
  logic [5:0] y6;
  logic [1:0] st8, st6;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decoder_nx_seq #(.SEL_W(3), .N_OUT(8), .CNT_W(4)) u8 (
    .clk(clk), .rst(rst), .en(en), .sel_valid(sel_valid), .sel(sel), .mode(mode),
    .pulse_len(pulse_len), .sel_ready(rdy8), .y(y8), .busy(busy8), .err(err8), .state(st8)
  );

  decoder_nx_seq #(.SEL_W(3), .N_OUT(6), .CNT_W(4)) u6 (
    .clk(clk), .rst(rst), .en(en), .sel_valid(sel_valid), .sel(sel), .mode(mode),
    .pulse_len(pulse_len), .sel_ready(rdy6), .y(y6), .busy(busy6), .err(err6), .state(st6)
  );

  logic [7:0] dy[2];
  logic       drdy[2], dbusy[2], derr[2];
  logic [1:0] dst[2];
  assign dy[0] = y8;
  assign dy[1] = {2'b00, y6};
  assign drdy[0] = rdy8;
  assign drdy[1] = rdy6;
  assign dbusy[0] = busy8;
  assign dbusy[1] = busy6;
  assign derr[0] = err8;
  assign derr[1] = err6;
  assign dst[0] = st8;
  assign dst[1] = st6;

  // Reference: kind 0 idle, 1 holding, 2 pulsing; left counts remaining high cycles.
  int         n_out[2] = '{8, 6};
  int         m_kind[2] = '{0, 0};
  int         m_left[2] = '{0, 0};
  logic [7:0] m_y[2] = '{8'h00, 8'h00};
  logic       m_busy[2] = '{1'b0, 1'b0};
  logic       m_err[2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] kind_state(input int k);
    case (k)
      1:       return HOLD;
      2:       return PULSE;
      default: return IDLE;
    endcase
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_kind[i] = 0; m_left[i] = 0; m_y[i] = '0; m_busy[i] = 1'b0; m_err[i] = 1'b0;
      end else begin
        m_err[i] = 1'b0;
        if (!en) begin
          m_kind[i] = 0; m_y[i] = '0; m_busy[i] = 1'b0;
        end else if (sel_valid && m_kind[i] != 2) begin
          if (int'(sel) >= n_out[i]) begin
            m_kind[i] = 0; m_y[i] = '0; m_busy[i] = 1'b0; m_err[i] = 1'b1;
          end else begin
            m_y[i] = 8'(1 << sel);
            if (mode) begin
              m_kind[i] = 2; m_left[i] = int'(pulse_len) + 1; m_busy[i] = 1'b1;
            end else begin
              m_kind[i] = 1; m_busy[i] = 1'b0;
            end
          end
        end else if (m_kind[i] == 2) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_kind[i] = 0; m_y[i] = '0; m_busy[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic v, input logic [2:0] s,
                       input logic m, input logic [3:0] pl);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("y%0d", n_out[i]), 64'(dy[i]), 64'(m_y[i]));
      check($sformatf("busy%0d", n_out[i]), 64'(dbusy[i]), 64'(m_busy[i]));
      check($sformatf("err%0d", n_out[i]), 64'(derr[i]), 64'(m_err[i]));
      check($sformatf("state%0d", n_out[i]), 64'(dst[i]), 64'(kind_state(m_kind[i])));
      check($sformatf("onehot0_%0d", n_out[i]), 64'($onehot0(dy[i])), 64'd1);
    end
    rst = r; en = e; sel_valid = v; sel = s; mode = m; pulse_len = pl;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("ready%0d", n_out[i]), 64'(drdy[i]), 64'(en && m_kind[i] != 2));
    @(posedge clk);
    model_step();
  endtask

  initial begin
    // Level decode after a two-cycle reset.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    for (int s = 0; s < 8; s++) cycle(0, 1, 1, 3'(s), MODE_LEVEL, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Pulse of four cycles with a select held waiting behind it.
    cycle(0, 1, 1, 5, MODE_PULSE, 3);
    for (int k = 0; k < 7; k++) cycle(0, 1, 1, 3, MODE_LEVEL, 0);
    // Out-of-range select from a held output.
    cycle(0, 1, 1, 2, MODE_LEVEL, 0);
    cycle(0, 1, 1, 7, MODE_PULSE, 5);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Enable drop in the middle of a long pulse.
    cycle(0, 1, 1, 4, MODE_PULSE, 9);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 3, MODE_LEVEL, 0);
    cycle(0, 1, 1, 2, MODE_LEVEL, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Reset while holding, then a normal decode.
    cycle(0, 1, 1, 4, MODE_LEVEL, 0);
    cycle(1, 1, 1, 6, MODE_PULSE, 5);
    cycle(0, 1, 1, 3, MODE_LEVEL, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Single-cycle pulses requested back to back.
    for (int k = 0; k < 4; k++) cycle(0, 1, 1, 1, MODE_PULSE, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Random traffic.
    for (int k = 0; k < 2000; k++)
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)));
    cycle(0, 1, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
